// File: rtl/fir_ctrl.sv
// fir_ctrl: sequences weight reload, sample shift, 4-cycle filter run and result handoff for an external FIR core.
// Optional WAIT watchdog is built when FIR_CTRL_TIMEOUT_EN is defined; otherwise err is tied low.
module fir_ctrl #(
   parameter int unsigned NTAPS = 16,
   parameter int unsigned TMO   = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic        cfg_valid,
   input  logic [15:0] cfg_data,
   output logic        cfg_ready,
   input  logic        s_valid,
   input  logic [15:0] s_data,
   output logic        s_ready,
   output logic        res_valid,
   output logic [15:0] res_data,
   input  logic        res_ready,
   output logic        fir_wind,
   output logic        fir_load,
   output logic        fir_in_valid,
   output logic [15:0] fir_data,
   input  logic        fir_out_valid,
   input  logic [15:0] fir_out,
   output logic        err
);

   localparam int unsigned CW = $clog2(NTAPS + 1);
   localparam logic [CW-1:0] LAST_W = CW'(NTAPS - 1);
   localparam logic [CW-1:0] FULL   = CW'(NTAPS);

   if (NTAPS < 2 || TMO < 1) begin : g_param_chk
      $error("fir_ctrl: NTAPS must be >= 2 and TMO >= 1");
   end

   typedef enum logic [2:0] {IDLE, WLOAD, READY, SHIFT, RUN, WAIT, OUT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0] prime_q, prime_d;
   logic [1:0]    run_q, run_d;
   logic          fir_wind_q, fir_wind_d;
   logic [15:0]   fir_data_q, fir_data_d;
   logic [15:0]   res_data_q, res_data_d;

`ifdef FIR_CTRL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // cfg_start has priority in READY, so a coincident sample is not accepted
   assign cfg_ready    = (state_q == WLOAD);
   assign s_ready      = (state_q == READY) && !cfg_start;
   assign fir_load     = (state_q == SHIFT);
   assign fir_in_valid = (state_q == RUN);
   assign res_valid    = (state_q == OUT);
   assign fir_wind     = fir_wind_q;
   assign fir_data     = fir_data_q;
   assign res_data     = res_data_q;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      prime_d    = prime_q;
      run_d      = run_q;
      fir_wind_d = 1'b0;
      fir_data_d = fir_data_q;
      res_data_d = res_data_q;
`ifdef FIR_CTRL_TIMEOUT_EN
      tmo_d      = '0;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = WLOAD;
               wcnt_d  = '0;
               prime_d = '0;
            end
         end
         WLOAD: begin
            if (cfg_valid) begin
               fir_wind_d = 1'b1;
               fir_data_d = cfg_data;
               if (wcnt_q == LAST_W) begin
                  wcnt_d  = '0;
                  state_d = READY;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         READY: begin
            if (cfg_start) begin
               state_d = WLOAD;
               wcnt_d  = '0;
               prime_d = '0;
            end else if (s_valid) begin
               fir_data_d = s_data;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (prime_q != FULL) prime_d = prime_q + 1'b1;
            run_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            run_d = run_q + 2'd1;
            if (run_q == 2'd3) state_d = WAIT;
         end
         WAIT: begin
            if (fir_out_valid) begin
               if (prime_q == FULL) begin
                  res_data_d = fir_out;
                  state_d    = OUT;
               end else begin
                  state_d = READY;
               end
            end
`ifdef FIR_CTRL_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = READY;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         OUT: begin
            if (res_ready) state_d = READY;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         prime_q    <= '0;
         run_q      <= '0;
         fir_wind_q <= 1'b0;
         fir_data_q <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         prime_q    <= prime_d;
         run_q      <= run_d;
         fir_wind_q <= fir_wind_d;
         fir_data_q <= fir_data_d;
         res_data_q <= res_data_d;
      end
   end

`ifdef FIR_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: randomized bench for fir_ctrl with a transaction-level expectation model and a responding filter model.
// Timeout checks are compiled when FIR_CTRL_TIMEOUT_EN is defined.
module tb_fir_ctrl;
   localparam int unsigned NTAPS = 16;
   localparam int unsigned TMO   = 32;

   logic        clk, rst;
   logic        cfg_start, cfg_valid, cfg_ready;
   logic [15:0] cfg_data;
   logic        s_valid, s_ready;
   logic [15:0] s_data;
   logic        res_valid, res_ready;
   logic [15:0] res_data;
   logic        fir_wind, fir_load, fir_in_valid;
   logic [15:0] fir_data;
   logic        fir_out_valid;
   logic [15:0] fir_out;
   logic        err;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned wind_cnt = 0;
   int unsigned load_cnt = 0;
   logic [15:0] model_out = '0;
   bit          model_on = 1'b1;

   fir_ctrl #(.NTAPS(NTAPS), .TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .fir_wind(fir_wind), .fir_load(fir_load), .fir_in_valid(fir_in_valid), .fir_data(fir_data),
      .fir_out_valid(fir_out_valid), .fir_out(fir_out), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Global drive rules observed every cycle
   always @(negedge clk) begin
      if (fir_wind) wind_cnt++;
      if (fir_load) load_cnt++;
      check("drive_exclusive", 32'(int'(fir_wind) + int'(fir_load) + int'(fir_in_valid) > 1), 0);
   end

   // Filter core model: answers some cycles after each complete 4-cycle run
   initial begin
      int unsigned ivc;
      int unsigned d;
      fir_out_valid = 1'b0;
      fir_out = 16'hdead;
      ivc = 0;
      forever begin
         @(negedge clk);
         ivc = fir_in_valid ? ivc + 1 : 0;
         if (ivc == 4) begin
            ivc = 0;
            if (model_on) begin
               d = $urandom_range(1, 4);
               repeat (d) @(posedge clk);
               #1 fir_out_valid = 1'b1;
               fir_out = model_out;
               @(posedge clk);
               #1 fir_out_valid = 1'b0;
               fir_out = 16'($urandom);
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {25'd0, cfg_ready, s_ready, res_valid, fir_wind, fir_load, fir_in_valid, err}, 0);
      check({tag, "_dat"}, {res_data, fir_data}, 0);
   endtask

   // Waits (bounded) for a handshake on cfg or sample channel; returns at the handshake edge + #1
   task automatic wait_hs(input bit is_cfg, input string tag);
      bit hs;
      int unsigned k;
      hs = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         hs = is_cfg ? cfg_ready : s_ready;
         @(posedge clk);
         k++;
      end while (!hs && k < 60);
      if (!hs) check({tag, "_timeout"}, 0, 1);
      #1;
   endtask

   task automatic start_cfg();
      cfg_start = 1'b1;
      @(posedge clk);
      #1 cfg_start = 1'b0;
   endtask

   task automatic load_weights(input bit seq);
      int unsigned w0;
      logic [15:0] w;
      w0 = wind_cnt;
      for (int i = 0; i < int'(NTAPS); i++) begin
         w = seq ? 16'(i + 1) : 16'($urandom);
         cfg_valid = 1'b1;
         cfg_data = w;
         cfg_start = ($urandom_range(0, 3) == 0);
         wait_hs(1'b1, "cfg_hs");
         cfg_valid = 1'b0;
         cfg_start = 1'b0;
         cfg_data = 16'($urandom);
         @(negedge clk);
         check("wind_pulse", fir_wind, 1);
         check("wind_data", fir_data, w);
         @(posedge clk);
         #1;
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end
      @(negedge clk);
      check("wind_count", wind_cnt - w0, NTAPS);
      check("cfg_ready_drop", cfg_ready, 0);
      check("ready_after_load", s_ready, 1);
      @(posedge clk);
      #1;
   endtask

   // One sample transaction; expect_res says whether the prime window is full.
   task automatic send_sample(input logic [15:0] sd, input logic [15:0] mo, input bit expect_res,
                              input int unsigned hold, input bit abort_run);
      bit prev_ov;
      int unsigned k;
      int unsigned wc, lc;
      model_out = mo;
      s_valid = 1'b1;
      s_data = sd;
      wait_hs(1'b0, "s_hs");
      s_valid = 1'b0;
      s_data = 16'($urandom);
      @(negedge clk);
      check("load_pulse", fir_load, 1);
      check("load_data", fir_data, sd);
      check("load_no_iv", fir_in_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("run_iv", fir_in_valid, 1);
         if (abort_run) begin
            @(posedge clk);
            #1 rst = 1'b1;
            wc = wind_cnt;
            lc = load_cnt;
            @(negedge clk);
            check_zero("abort_rst");
            @(negedge clk);
            check_zero("abort_rst2");
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (3) @(negedge clk);
            check("abort_idle", {cfg_ready, s_ready, res_valid}, 0);
            check("abort_no_pulse", (wind_cnt - wc) + (load_cnt - lc), 0);
            @(posedge clk);
            #1;
            return;
         end
      end
      prev_ov = 1'b0;
      k = 0;
      @(negedge clk);
      check("run_len", fir_in_valid, 0);
      while (!res_valid && !s_ready && k < 60) begin
         prev_ov = fir_out_valid;
         @(negedge clk);
         k++;
      end
      if (expect_res) begin
         check("res_seen", res_valid, 1);
         check("res_latency", prev_ov, 1);
         check("res_data", res_data, mo);
         for (int h = 0; h < int'(hold); h++) begin
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, mo);
            check("hold_s_ready", s_ready, 0);
         end
         @(posedge clk);
         #1 res_ready = 1'b1;
         @(posedge clk);
         #1 res_ready = 1'b0;
         @(negedge clk);
         check("res_drop", res_valid, 0);
         check("ready_after_res", s_ready, 1);
      end else begin
         check("no_res", res_valid, 0);
         check("ready_after_discard", s_ready, 1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data = 16'hbeef;
      s_valid = 1'b1;
      s_data = 16'hcafe;
      res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      s_valid = 1'b0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_reset", {cfg_ready, s_ready, res_valid}, 0);
      @(posedge clk);
      #1;

      start_cfg();
      load_weights(1'b1);

      for (int i = 0; i < int'(NTAPS) - 1; i++)
         send_sample(16'($urandom), 16'($urandom), 1'b0, 0, 1'b0);
      send_sample(16'($urandom), 16'h1234, 1'b1, 10, 1'b0);
      for (int i = 0; i < 5; i++)
         send_sample(16'($urandom), 16'($urandom), 1'b1, $urandom_range(0, 4), 1'b0);

      // Reload from READY clears the prime window
      start_cfg();
      load_weights(1'b0);
      send_sample(16'($urandom), 16'($urandom), 1'b0, 0, 1'b0);

      // Reset during the 2nd RUN cycle, then a full fresh priming
      send_sample(16'($urandom), 16'($urandom), 1'b0, 0, 1'b1);
      start_cfg();
      load_weights(1'b0);
      for (int i = 0; i < int'(NTAPS); i++)
         send_sample(16'($urandom), 16'($urandom), i == int'(NTAPS) - 1, 2, 1'b0);

`ifdef FIR_CTRL_TIMEOUT_EN
      model_on = 1'b0;
      s_valid = 1'b1;
      s_data = 16'($urandom);
      wait_hs(1'b0, "tmo_s_hs");
      s_valid = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 1; k <= int'(TMO); k++) begin
         @(negedge clk);
         if (k == int'(TMO)) begin
            check("tmo_err_early", err, 0);
            check("tmo_ready_early", s_ready, 0);
         end
      end
      @(negedge clk);
      check("tmo_err", err, 1);
      check("tmo_ready", s_ready, 1);
      check("tmo_no_res", res_valid, 0);
      model_on = 1'b1;
      @(posedge clk);
      #1;
      send_sample(16'($urandom), 16'h5a5a, 1'b1, 1, 1'b0);
      check("err_sticky", err, 1);
`else
      check("err_tied", err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
